// File: rtl/mod_n_digit_counter.sv
// Cascaded mod-MODULUS digit counter with +1/+2/-1 steps, range-checked parallel load,
// and registered overflow/underflow and load-error pulses.
module mod_n_digit_counter #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DIGITS  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [1:0]                mode_i,
  input  logic                      load_i,
  input  logic [DIGITS*WIDTH-1:0]   load_value_i,
  output logic [DIGITS*WIDTH-1:0]   count_o,
  output logic                      wrap_o,
  output logic                      load_err_o
);

  if (MODULUS < 2 || MODULUS > 16 || DIGITS < 1 || DIGITS > 8 ||
      (64'(1) << WIDTH) < 64'(MODULUS)) begin : gen_bad_params
    $error("mod_n_digit_counter: illegal MODULUS/WIDTH/DIGITS combination");
  end

  localparam logic [WIDTH:0]   ModW     = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxDigit = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeInc1 = 2'b01,
    ModeInc2 = 2'b10,
    ModeDec  = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(mode_i);

  logic [DIGITS*WIDTH-1:0] count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic                    load_err_q, load_err_d;
  logic [WIDTH-1:0]        digit;
  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          ripple;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    digit      = '0;
    sum        = '0;
    ripple     = '0;
    if (load_i) begin
      for (int k = 0; k < DIGITS; k++) begin
        digit = load_value_i[k*WIDTH +: WIDTH];
        if ({1'b0, digit} < ModW) begin
          count_d[k*WIDTH +: WIDTH] = digit;
        end else begin
          count_d[k*WIDTH +: WIDTH] = '0;
          load_err_d                = 1'b1;
        end
      end
    end else if (en_i && mode != ModeHold) begin
      // Digit 0 receives the step itself; every higher digit only a 0/1 carry or borrow.
      ripple = (mode == ModeInc2) ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
      for (int k = 0; k < DIGITS; k++) begin
        digit = count_q[k*WIDTH +: WIDTH];
        if (mode == ModeDec) begin
          if (ripple != '0 && digit == '0) begin
            count_d[k*WIDTH +: WIDTH] = MaxDigit;
            ripple                    = (WIDTH+1)'(1);
          end else begin
            count_d[k*WIDTH +: WIDTH] = digit - ripple[WIDTH-1:0];
            ripple                    = '0;
          end
        end else begin
          sum = {1'b0, digit} + ripple;
          if (sum >= ModW) begin
            sum    = sum - ModW;
            ripple = (WIDTH+1)'(1);
          end else begin
            ripple = '0;
          end
          count_d[k*WIDTH +: WIDTH] = sum[WIDTH-1:0];
        end
      end
      wrap_d = ripple[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = load_err_q;

endmodule
